// File: rtl/tile_pkg.sv
// Shared types and constants for the tile row scaler.
//   state_e    : control FSM states
//   CFG_*      : bit positions of the fields in the 16-bit config word
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CFG_BIAS_LSB  = 0;
  localparam int CFG_BIAS_MSB  = 7;
  localparam int CFG_SHIFT_LSB = 8;
  localparam int CFG_SHIFT_MSB = 11;
  localparam int CFG_BYPASS    = 12;

endpackage

// File: rtl/tile_row_lane.sv
// Combinational processing of one tile row.
//   row_in  : COLS unsigned elements of DATA_W bits
//   bias    : value added before the shift, already sized to DATA_W
//   shift   : right-shift amount; DATA_W or more yields zero
//   bypass  : pass elements through unchanged
//   row_out : processed elements
//   row_max : largest processed element of the row
module tile_row_lane #(
  parameter int COLS   = 16,
  parameter int DATA_W = 8
) (
  input  logic [0:COLS-1][DATA_W-1:0] row_in,
  input  logic [DATA_W-1:0]           bias,
  input  logic [3:0]                  shift,
  input  logic                        bypass,
  output logic [0:COLS-1][DATA_W-1:0] row_out,
  output logic [DATA_W-1:0]           row_max
);

  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] sat_s;
  logic [DATA_W-1:0] elem_s;

  // Per-column saturating add, shift/bypass and running row maximum.
  always_comb begin
    row_out = '0;
    row_max = '0;
    sum_s   = '0;
    sat_s   = '0;
    elem_s  = '0;
    for (int c = 0; c < COLS; c++) begin
      // One extra bit catches the carry out of the add.
      sum_s = {1'b0, row_in[c]} + {1'b0, bias};
      if (sum_s[DATA_W]) begin
        sat_s = '1;
      end else begin
        sat_s = sum_s[DATA_W-1:0];
      end
      if (bypass) begin
        elem_s = row_in[c];
      end else if ({1'b0, shift} >= 5'(DATA_W)) begin
        elem_s = '0;
      end else begin
        elem_s = sat_s >> shift;
      end
      row_out[c] = elem_s;
      if (elem_s > row_max) begin
        row_max = elem_s;
      end else begin
        row_max = row_max;
      end
    end
  end

endmodule

// File: rtl/tile_row_scaler.sv
// Tile row scaler: accepts a ROWS x COLS tile plus config over valid/ready,
// processes one row per cycle and presents the tile and its maximum.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_tile, in_cfg       : input tile and config word (bias/shift/bypass)
//   in_valid, in_ready    : input handshake
//   out_tile, out_max     : processed tile and its maximum element
//   out_valid, out_ready  : output handshake
module tile_row_scaler
  import tile_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 16,
  parameter int DATA_W = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]  in_tile,
  input  logic [15:0]                            in_cfg,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]  out_tile,
  output logic [DATA_W-1:0]                      out_max,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                                 state_r;
  state_e                                 state_next_s;
  logic [ROW_W-1:0]                       row_r;
  logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]  tile_r;
  logic [DATA_W-1:0]                      bias_r;
  logic [3:0]                             shift_r;
  logic                                   bypass_r;
  logic [0:COLS-1][DATA_W-1:0]            row_sel_s;
  logic [0:COLS-1][DATA_W-1:0]            row_out_s;
  logic [DATA_W-1:0]                      row_max_s;
  logic                                   accept_s;
  logic                                   last_row_s;
  logic                                   unused_cfg_s;

  // Reserved config bits are deliberately ignored.
  assign unused_cfg_s = ^in_cfg[15:13];

  // A finished result may retire in the same cycle a new tile is taken.
  assign in_ready   = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s   = in_valid && in_ready;
  assign last_row_s = (row_r == ROW_W'(ROWS - 1));

  // Select the captured row addressed by the row counter.
  always_comb begin
    row_sel_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_r == ROW_W'(r)) begin
        row_sel_s = tile_r[r];
      end else begin
        row_sel_s = row_sel_s;
      end
    end
  end

  tile_row_lane #(
    .COLS   (COLS),
    .DATA_W (DATA_W)
  ) u_lane (
    .row_in  (row_sel_s),
    .bias    (bias_r),
    .shift   (shift_r),
    .bypass  (bypass_r),
    .row_out (row_out_s),
    .row_max (row_max_s)
  );

  // Next-state logic for the control FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = PROC;
        end else begin
          state_next_s = IDLE;
        end
      end
      PROC: begin
        if (last_row_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = PROC;
        end
      end
      DONE: begin
        if (out_ready && in_valid) begin
          state_next_s = PROC;
        end else if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture registers, row counter, output tile and max accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r     <= '0;
      tile_r    <= '0;
      bias_r    <= '0;
      shift_r   <= 4'd0;
      bypass_r  <= 1'b0;
      out_tile  <= '0;
      out_max   <= '0;
      out_valid <= 1'b0;
    end else if (accept_s) begin
      // Config is frozen here for the whole tile.
      tile_r    <= in_tile;
      bias_r    <= DATA_W'(in_cfg[CFG_BIAS_MSB:CFG_BIAS_LSB]);
      shift_r   <= in_cfg[CFG_SHIFT_MSB:CFG_SHIFT_LSB];
      bypass_r  <= in_cfg[CFG_BYPASS];
      row_r     <= '0;
      out_max   <= '0;
      out_valid <= 1'b0;
    end else if (state_r == PROC) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_r == ROW_W'(r)) begin
          out_tile[r] <= row_out_s;
        end
      end
      if (row_max_s > out_max) begin
        out_max <= row_max_s;
      end
      if (last_row_s) begin
        out_valid <= 1'b1;
      end else begin
        row_r <= row_r + ROW_W'(1);
      end
    end else if ((state_r == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_row_scaler.sv
module tb_tile_row_scaler;

  typedef logic [0:7][0:15][7:0] tile_t;
  typedef logic [0:0][0:2][11:0] ptile_t;
  typedef struct packed { tile_t tile; logic [7:0] mx; } exp_t;
  typedef struct packed { ptile_t tile; logic [11:0] mx; } pexp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;

  // Default-parameter DUT signals
  tile_t       in_tile, out_tile;
  logic [15:0] in_cfg;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  out_max;

  // ROWS=1, COLS=3, DATA_W=12 DUT signals
  ptile_t      p_in_tile, p_out_tile;
  logic [15:0] p_in_cfg;
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [11:0] p_out_max;

  exp_t  sb_q[$];
  pexp_t p_q[$];
  int    ret_q[$];

  tile_row_scaler dut (
    .clk(clk), .rst_n(rst_n), .in_tile(in_tile), .in_cfg(in_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .out_tile(out_tile),
    .out_max(out_max), .out_valid(out_valid), .out_ready(out_ready)
  );

  tile_row_scaler #(.ROWS(1), .COLS(3), .DATA_W(12)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_tile(p_in_tile), .in_cfg(p_in_cfg),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .out_tile(p_out_tile),
    .out_max(p_out_max), .out_valid(p_out_valid), .out_ready(p_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic tile_t fill(input logic [7:0] v);
    tile_t t;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) t[r][c] = v;
    return t;
  endfunction

  // Scoreboard monitor, default DUT: a handshake completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_out: got result %0h expected none", out_max);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_tile", out_tile, e.tile);
        chk("out_max", out_max, e.mx);
        ret_q.push_back(cyc);
      end
    end
  end

  // Scoreboard monitor, small DUT.
  always @(negedge clk) begin
    if (rst_n && p_out_valid && p_out_ready) begin
      if (p_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL p_unexpected_out: got result %0h expected none", p_out_max);
      end else begin
        pexp_t e;
        e = p_q.pop_front();
        chk("p_out_tile", p_out_tile, e.tile);
        chk("p_out_max", p_out_max, e.mx);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input tile_t t, input logic [15:0] cfg, input tile_t et, input logic [7:0] em);
    int n;
    exp_t e;
    in_tile = t; in_cfg = cfg; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("send_ready", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      e.tile = et; e.mx = em;
      sb_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_p(input ptile_t t, input logic [15:0] cfg, input ptile_t et, input logic [11:0] em);
    pexp_t e;
    p_in_tile = t; p_in_cfg = cfg; p_in_valid = 1'b1;
    #1;
    chk("p_send_ready", p_in_ready, 1);
    @(posedge clk);
    e.tile = et; e.mx = em;
    p_q.push_back(e);
    #1 p_in_valid = 1'b0;
    chk("p_lat0", p_out_valid, 0);
    @(posedge clk); #1;
    chk("p_lat1", p_out_valid, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || p_q.size() != 0) && n < 400) begin @(posedge clk); #1; n++; end
    chk("drain", sb_q.size() + p_q.size(), 0);
  endtask

  initial begin
    tile_t  a, b, t1, t2, e2;
    ptile_t pt, pe;
    int     n;
    cyc = 0; chk_cnt = 0; pass_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_tile = '0; in_cfg = 16'h0000;
    p_in_valid = 1'b0; p_out_ready = 1'b1; p_in_tile = '0; p_in_cfg = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_tile", out_tile, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // bias 5, shift 1: (0x10+5)>>1 = 0x0A; latency exactly 8 edges
    send(fill(8'h10), 16'h0105, fill(8'h0A), 8'h0A);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_edge%0d", k), out_valid, (k == 8));
    end
    wait_drain();

    // Reset in the middle of processing discards the tile
    send(fill(8'h20), 16'h0000, fill(8'h20), 8'h20);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_max", out_max, 0);
    chk("midrst_out_tile", out_tile, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("midrst_no_pulse", out_valid, 0);

    // Saturation, oversized shift, bypass
    send(fill(8'hFE), 16'h0010, fill(8'hFF), 8'hFF);
    send(fill(8'hFE), 16'h0810, fill(8'h00), 8'h00);
    send(fill(8'hFE), 16'h1310, fill(8'hFE), 8'hFE);
    wait_drain();

    // Backpressure held for 20 cycles with a new tile pending
    a = fill(8'h33); a[3][7] = 8'h99;
    out_ready = 1'b0;
    send(a, 16'h1000, a, 8'h99);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", out_valid, 1);
    in_tile = fill(8'h05); in_cfg = 16'h0003; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_tile_hold", out_tile, a);
      chk("bp_max_hold", out_max, 8'h99);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    begin
      exp_t e;
      e.tile = fill(8'h08); e.mx = 8'h08;
      sb_q.push_back(e);
    end
    #1 in_valid = 1'b0;
    chk("bp_retired", out_valid, 0);
    wait_drain();

    // Back-to-back stream of three tiles
    ret_q.delete();
    t1 = fill(8'h01);
    for (int c = 0; c < 16; c++) t1[5][c] = 8'h30 + 8'(c);
    t2 = fill(8'h02); e2 = fill(8'h01);
    for (int c = 0; c < 16; c++) begin
      t2[0][c] = 8'h80 + 8'(c);
      e2[0][c] = 8'h40 + 8'(c / 2);
    end
    send(t1, 16'h0000, t1, 8'h3F);
    send(t2, 16'h0100, e2, 8'h47);
    send(fill(8'h40), 16'hE4F0, fill(8'h0F), 8'h0F);
    wait_drain();
    chk("b2b_count", ret_q.size(), 3);
    if (ret_q.size() == 3) begin
      chk("b2b_gap1", ret_q[1] - ret_q[0], 9);
      chk("b2b_gap2", ret_q[2] - ret_q[1], 9);
    end

    // Small configuration: ROWS=1, COLS=3, DATA_W=12
    pt = {12'hFFF, 12'hFFF, 12'hFFF};
    send_p(pt, 16'h0001, pt, 12'hFFF);
    @(posedge clk); #1;
    send_p(pt, 16'hE001, pt, 12'hFFF);
    @(posedge clk); #1;
    pt = {12'h100, 12'h200, 12'h300};
    pe = {12'h01F, 12'h02F, 12'h03F};
    send_p(pt, 16'h04FF, pe, 12'h03F);
    @(posedge clk); #1;
    send_p(pt, 16'h0C00, '0, 12'h000);
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
